// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller.
package trap_pkg;

  localparam int FETCH_ERR  = 0;
  localparam int DECODE_ERR = 1;
  localparam int ANOMALY    = 2;
  localparam int ECALL      = 3;
  localparam int EBREAK     = 4;

  localparam logic [5:0] CAUSE_FETCH   = 6'd1;
  localparam logic [5:0] CAUSE_ILLEGAL = 6'd2;
  localparam logic [5:0] CAUSE_BREAK   = 6'd3;
  localparam logic [5:0] CAUSE_ECALL   = 6'd11;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_HALT,
    ST_FATAL
  } state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Resolves a retiring instruction's exception bits into one action.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic       valid_i,
  input  logic [7:0] exceptions_i,
  output logic       take_trap,
  output logic       go_halt,
  output logic       go_fatal,
  output logic [5:0] cause
);

  logic unused_rsvd;
  assign unused_rsvd = ^exceptions_i[7:5];

  always_comb begin
    take_trap = 1'b0;
    go_halt   = 1'b0;
    go_fatal  = 1'b0;
    cause     = '0;
    if (valid_i) begin
      priority case (1'b1)
        exceptions_i[ANOMALY]: go_fatal = 1'b1;
        exceptions_i[FETCH_ERR]: begin
          take_trap = 1'b1;
          cause     = CAUSE_FETCH;
        end
        exceptions_i[DECODE_ERR]: begin
          take_trap = 1'b1;
          cause     = CAUSE_ILLEGAL;
        end
        exceptions_i[ECALL]: begin
          take_trap = 1'b1;
          cause     = CAUSE_ECALL;
        end
        exceptions_i[EBREAK]: go_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller: CSRs, trap entry, MRET and halt/fatal.
module trap_unit
  import trap_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] TVEC_RESET = 64'h8000_0100
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [7:0]            exceptions_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] tval_i,
  input  logic                  mret_i,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  stall_o,
  output logic                  halt_o,
  output logic                  fatal_o
);

  localparam int DW = DATA_WIDTH;

  state_e        state_q;
  logic [DW-1:0] mtvec_q;
  logic [DW-1:0] mepc_q;
  logic [DW-1:0] mcause_q;
  logic [DW-1:0] mtval_q;
  logic          redirect_q;
  logic [DW-1:0] redirect_pc_q;

  logic       take_trap;
  logic       go_halt;
  logic       go_fatal;
  logic [5:0] cause;

  logic idle_ok;
  logic ev_enter;
  logic ev_halt;
  logic ev_fatal;
  logic ev_mret;
  logic ev_any;
  logic csr_wr;
  logic unused_pc;

  assign unused_pc = ^pc_i[1:0];

  trap_prio_enc u_prio (
    .valid_i      (valid_i),
    .exceptions_i (exceptions_i),
    .take_trap    (take_trap),
    .go_halt      (go_halt),
    .go_fatal     (go_fatal),
    .cause        (cause)
  );

  // Nothing is accepted while a redirect is in flight, so redirect never repeats.
  assign idle_ok  = (state_q == ST_IDLE) && !redirect_q;
  assign ev_fatal = idle_ok && (go_fatal || (take_trap && mtvec_q == '0));
  assign ev_enter = idle_ok && take_trap && (mtvec_q != '0);
  assign ev_halt  = idle_ok && go_halt;
  assign ev_mret  = idle_ok && valid_i && mret_i
                 && !(take_trap || go_halt || go_fatal);
  assign ev_any   = ev_fatal || ev_enter || ev_halt || ev_mret;
  assign csr_wr   = csr_we_i && !ev_any
                 && (state_q == ST_IDLE || state_q == ST_ENTER);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      mtvec_q       <= TVEC_RESET;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= ev_enter || ev_mret;
      if (ev_enter)
        redirect_pc_q <= {mtvec_q[DW-1:2], 2'b00};
      else if (ev_mret)
        redirect_pc_q <= mepc_q;
      else
        redirect_pc_q <= '0;

      unique case (state_q)
        ST_IDLE: begin
          if (ev_fatal)      state_q <= ST_FATAL;
          else if (ev_halt)  state_q <= ST_HALT;
          else if (ev_enter) state_q <= ST_ENTER;
        end
        ST_ENTER: state_q <= ST_IDLE;
        ST_HALT:  state_q <= ST_HALT;
        ST_FATAL: state_q <= ST_FATAL;
      endcase

      if (ev_enter) begin
        mepc_q   <= {pc_i[DW-1:2], 2'b00};
        mcause_q <= {{(DW-6){1'b0}}, cause};
        mtval_q  <= tval_i;
      end

      if (csr_wr) begin
        unique case (csr_addr_i)
          CSR_MTVEC:  mtvec_q  <= {csr_wdata_i[DW-1:2], 2'b00};
          CSR_MEPC:   mepc_q   <= {csr_wdata_i[DW-1:2], 2'b00};
          CSR_MCAUSE: mcause_q <= {1'b0, csr_wdata_i[DW-2:0]};
          CSR_MTVAL:  mtval_q  <= csr_wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_addr_i)
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MTVAL:  csr_rdata_o = mtval_q;
      default: ;
    endcase
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign stall_o       = (state_q == ST_ENTER);
  assign halt_o        = (state_q == ST_HALT);
  assign fatal_o       = (state_q == ST_FATAL);

endmodule
